// File: rtl/divisor_secuencial_param.sv
// Multi-cycle restoring divider, signed/unsigned, BITS_POR_CICLO quotient bits per clock.
// Latency: Done tamanyo/BITS_POR_CICLO+1 edges after the accepting edge (1 edge on divide-by-zero).
// Backpressure: one division in flight; Start is ignored while Ready=0.
module divisor_secuencial_param #(
    parameter int tamanyo        = 32,
    parameter int BITS_POR_CICLO = 1
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic               Signo,
    input  logic [tamanyo-1:0] Num,
    input  logic [tamanyo-1:0] Den,
    output logic               Ready,
    output logic               Done,
    output logic [tamanyo-1:0] Coc,
    output logic [tamanyo-1:0] Res,
    output logic               DivCero,
    output logic               Ovf
);
    localparam int N  = tamanyo / BITS_POR_CICLO;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]      LAST     = CW'(N - 1);
    localparam logic [tamanyo-1:0] MOST_NEG = {1'b1, {(tamanyo-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state;

    logic [tamanyo-1:0] accu, q, m;
    logic [CW-1:0]      cnt;
    logic               sn, sd, dz, ov;

    logic               num_neg, den_neg, den_zero;
    logic [tamanyo-1:0] num_abs, den_abs;

    // The magnitude of the most-negative value keeps its bit pattern, read as unsigned.
    assign num_neg  = Signo & Num[tamanyo-1];
    assign den_neg  = Signo & Den[tamanyo-1];
    assign num_abs  = num_neg ? -Num : Num;
    assign den_abs  = den_neg ? -Den : Den;
    assign den_zero = (Den == '0);

    logic [tamanyo:0]   sh;
    logic [tamanyo-1:0] accu_nxt, q_nxt;

    always_comb begin
        sh       = '0;
        accu_nxt = accu;
        q_nxt    = q;
        for (int i = 0; i < BITS_POR_CICLO; i++) begin
            // Shifted value is tamanyo+1 bits so the carry-out takes part in the compare.
            sh    = {accu_nxt, q_nxt[tamanyo-1]};
            q_nxt = {q_nxt[tamanyo-2:0], 1'b0};
            if (sh >= {1'b0, m}) begin
                sh       = sh - {1'b0, m};
                q_nxt[0] = 1'b1;
            end
            accu_nxt = sh[tamanyo-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state   <= IDLE;
            Ready   <= 1'b1;
            Done    <= 1'b0;
            Coc     <= '0;
            Res     <= '0;
            DivCero <= 1'b0;
            Ovf     <= 1'b0;
            accu    <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            sn      <= 1'b0;
            sd      <= 1'b0;
            dz      <= 1'b0;
            ov      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        sn      <= num_neg;
                        sd      <= den_neg;
                        q       <= num_abs;
                        m       <= den_abs;
                        cnt     <= '0;
                        DivCero <= 1'b0;
                        Ovf     <= 1'b0;
                        dz      <= den_zero;
                        ov      <= Signo && (Num == MOST_NEG) && (Den == '1);
                        Ready   <= 1'b0;
                        // Divide-by-zero parks |Num| in the accumulator so the sign fix restores Num.
                        if (den_zero) begin
                            accu  <= num_abs;
                            state <= FIX;
                        end else begin
                            accu  <= '0;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    accu <= accu_nxt;
                    q    <= q_nxt;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    Coc     <= dz ? '1 : ((sn ^ sd) ? -q : q);
                    Res     <= sn ? -accu : accu;
                    DivCero <= dz;
                    Ovf     <= ov;
                    Done    <= 1'b1;
                    Ready   <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_secuencial_param.sv
// Bench for divisor_secuencial_param: two instances (1 and 4 bits per clock) against a
// scoreboard fed by an arithmetic reference model.
module tb_divisor_secuencial_param;
    localparam int W  = 32;
    localparam int N1 = W / 1;
    localparam int N4 = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         signo = 1'b0;
    logic         start1 = 1'b0, start4 = 1'b0;
    logic [W-1:0] num = '0, den = '0;

    logic         rdy1, done1, dz1, ov1;
    logic [W-1:0] coc1, res1;
    logic         rdy4, done4, dz4, ov4;
    logic [W-1:0] coc4, res4;

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    divisor_secuencial_param #(.tamanyo(W), .BITS_POR_CICLO(1)) dut1 (
        .CLK(clk), .RSTa(rst_n), .Start(start1), .Signo(signo), .Num(num), .Den(den),
        .Ready(rdy1), .Done(done1), .Coc(coc1), .Res(res1), .DivCero(dz1), .Ovf(ov1)
    );

    divisor_secuencial_param #(.tamanyo(W), .BITS_POR_CICLO(4)) dut4 (
        .CLK(clk), .RSTa(rst_n), .Start(start4), .Signo(signo), .Num(num), .Den(den),
        .Ready(rdy4), .Done(done4), .Coc(coc4), .Res(res4), .DivCero(dz4), .Ovf(ov4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] coc;
        logic [W-1:0] res;
        logic         dz;
        logic         ov;
        int           due;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    // Reference: plain truncating division on 64-bit integers.
    function automatic exp_t model(input logic s, input logic [W-1:0] n, input logic [W-1:0] d,
                                   input int due);
        exp_t   e;
        longint a, b, qq, rr;
        e.due = due;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (d == '0) begin
            e.coc = '1;
            e.res = n;
            e.dz  = 1'b1;
        end else if (s) begin
            a     = longint'($signed(n));
            b     = longint'($signed(d));
            qq    = a / b;
            rr    = a % b;
            e.coc = qq[W-1:0];
            e.res = rr[W-1:0];
            e.ov  = (qq > 64'sd2147483647);
        end else begin
            e.coc = n / d;
            e.res = n % d;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_done(input bit w, input logic [W-1:0] coc, input logic [W-1:0] res,
                              input logic dz, input logic ov, input logic rdy);
        exp_t e;
        if ((w && q4.size() == 0) || (!w && q1.size() == 0)) begin
            nvec++;
            nbad++;
            $display("FAIL spurious_done dut%0d: Done=1 with nothing outstanding, required Done=0",
                     w ? 4 : 1);
            return;
        end
        if (w) e = q4.pop_front();
        else   e = q1.pop_front();
        chk("coc", coc, e.coc);
        chk("res", res, e.res);
        chk("divcero", dz, e.dz);
        chk("ovf", ov, e.ov);
        chk("done_cycle", cyc, e.due);
        chk("ready_with_done", rdy, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done1 === 1'b1) check_done(1'b0, coc1, res1, dz1, ov1, rdy1);
        if (rst_n === 1'b1 && done4 === 1'b1) check_done(1'b1, coc4, res4, dz4, ov4, rdy4);
    end

    task automatic issue(input bit w, input logic s, input logic [W-1:0] n,
                         input logic [W-1:0] d, input bit at_done);
        int   k;
        int   lat;
        int   i;
        logic r;
        if (at_done) begin
            i = 0;
            do begin
                @(negedge clk);
                i++;
            end while (!(w ? done4 : done1) && i < 200);
            if (i >= 200) begin
                nvec++;
                nbad++;
                $display("FAIL b2b_wait dut%0d: no Done within 200 clocks, required Done=1", w ? 4 : 1);
            end
        end else begin
            @(negedge clk);
        end
        signo = s;
        num   = n;
        den   = d;
        r     = w ? rdy4 : rdy1;
        chk("ready_at_start", r, 1'b1);
        if (w) start4 = 1'b1;
        else   start1 = 1'b1;
        @(posedge clk);
        #1;
        k      = cyc;
        start1 = 1'b0;
        start4 = 1'b0;
        lat    = (d == '0) ? 1 : ((w ? N4 : N1) + 1);
        if (w) q4.push_back(model(s, n, d, k + lat));
        else   q1.push_back(model(s, n, d, k + lat));
    endtask

    task automatic wait_idle(input bit w);
        int i;
        i = 0;
        while (((w && q4.size() != 0) || (!w && q1.size() != 0)) && i < 200) begin
            @(negedge clk);
            i++;
        end
        if ((w && q4.size() != 0) || (!w && q1.size() != 0)) begin
            nvec++;
            nbad++;
            $display("FAIL timeout dut%0d: result still outstanding after 200 clocks, required Done",
                     w ? 4 : 1);
            if (w) q4.delete();
            else   q1.delete();
        end
    endtask

    function automatic logic [W-1:0] rnd_op(input int kind);
        logic [W-1:0] v;
        v = $urandom();
        case (kind)
            0: v = '0;
            1: v = W'($urandom_range(1, 15));
            2: v = -W'($urandom_range(1, 15));
            3: v = 32'h8000_0000;
            4: v = '1;
            5: v = W'($urandom_range(1, 65535));
            default: ;
        endcase
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready1"}, rdy1, 1'b1);
        chk({tag, "_done1"}, done1, 1'b0);
        chk({tag, "_coc1"}, coc1, '0);
        chk({tag, "_res1"}, res1, '0);
        chk({tag, "_flags1"}, {dz1, ov1}, 2'b00);
        chk({tag, "_ready4"}, rdy4, 1'b1);
        chk({tag, "_coc4"}, coc4, '0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Directed cases
        issue(0, 1'b0, 32'd100, 32'd7, 0);               wait_idle(0);
        issue(0, 1'b1, -32'd100, 32'd7, 0);              wait_idle(0);
        issue(0, 1'b1, 32'd100, -32'd7, 0);              wait_idle(0);
        issue(0, 1'b0, 32'd7, 32'd0, 0);                 wait_idle(0);
        issue(0, 1'b1, 32'h8000_0000, 32'd0, 0);         wait_idle(0);
        issue(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_idle(0);
        issue(0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_idle(0);

        // Four-bit-per-clock instance with ignored Starts while busy
        issue(1, 1'b0, 32'hFFFF_FFFF, 32'd3, 0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            signo  = 1'b1;
            num    = $urandom();
            den    = $urandom();
            chk("busy_ready4", rdy4, 1'b0);
            start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        wait_idle(1);

        // Back-to-back: new Start in the Done cycle
        issue(1, 1'b1, 32'd1000, 32'd9, 0);
        issue(1, 1'b1, -32'd1000, 32'd9, 1);
        issue(1, 1'b0, 32'd5, 32'd0, 1);
        wait_idle(1);

        // Reset mid-division, then a normal division
        issue(0, 1'b0, 32'd12345, 32'd67, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        q1.delete();
        check_reset_vals("midrst");
        @(negedge clk);
        chk("midrst_no_done", done1, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_rst_no_done", done1, 1'b0);
        issue(0, 1'b0, 32'd12345, 32'd67, 0);
        wait_idle(0);

        // Randomized traffic on both instances
        for (int i = 0; i < 40; i++) begin
            bit w;
            bit b2b;
            logic s;
            logic [W-1:0] n, d;
            w   = i[0];
            s   = 1'($urandom_range(0, 1));
            n   = rnd_op($urandom_range(1, 9));
            d   = rnd_op($urandom_range(0, 9));
            b2b = ((w && q4.size() != 0) || (!w && q1.size() != 0)) && ($urandom_range(0, 1) == 1);
            if (!b2b) wait_idle(w);
            issue(w, s, n, d, b2b);
            if ($urandom_range(0, 2) == 0) wait_idle(w);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #1_000_000;
        nbad++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
